rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8: the maximum consecutive cycles one requester holds the grant while another requester waits; legal range 2..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-004 Port req, input, 4 bits: request lines; bit i means requester i wants the shared resource.
REQ-005 Port gnt, output, 4 bits: registered one-hot grant; all zeros when no grant is held.
REQ-006 Port gnt_idx, output, 2 bits: registered binary index of the owner; 0 when no grant is held.
REQ-007 Port gnt_valid, output, 1 bit: registered; high exactly when gnt is non-zero.

Function
REQ-008 The block SHALL use two states: IDLE (no owner) and BUSY (owner held in the owner register).
REQ-009 IDLE -> BUSY: at the first edge where req != 0, the owner SHALL be the first asserted bit searching upward, modulo 4, from last+1, where last is the previous owner.
REQ-010 Grant latency SHALL be one cycle: req sampled at edge N appears as gnt from edge N onward; gnt has no combinational path from req.
REQ-011 In BUSY, the grant SHALL be held while req[owner]=1 and the hold counter has not expired.
REQ-012 Owner drop: if req[owner]=0 at an edge and other requests are pending, the grant SHALL move to the next round-robin winner at that same edge, with no idle bubble.
REQ-013 Owner drop with no other request pending: the block SHALL go to IDLE at that edge, with gnt=0, gnt_valid=0 and gnt_idx=0.
REQ-014 The hold counter SHALL clear to 0 on every new grant and increment once per BUSY cycle.
REQ-015 The hold counter SHALL saturate at MAX_HOLD-1.
REQ-016 The counter SHALL be ceil(log2(MAX_HOLD)) bits wide.
REQ-017 Forced rotation: if the counter equals MAX_HOLD-1 and any other req bit is set, the next edge SHALL grant the next round-robin winner, even if req[owner] is still 1.
REQ-018 If the counter is saturated and no other request is pending, the owner SHALL keep the grant indefinitely.
REQ-019 Search rule: the current owner SHALL be the lowest-priority candidate; it is rechosen only when it is the sole requester and req[owner]=1.
REQ-020 gnt SHALL always equal the 2-to-4 decode of gnt_idx, gated by gnt_valid; more than one bit high is illegal.
REQ-021 last SHALL update to the owner's index on every new grant; last is unchanged in IDLE.
REQ-022 Simultaneous events: owner drop and counter expiry in the same cycle SHALL resolve per REQ-012/REQ-013; a single switch, never a double advance.

Reset
REQ-023 While rst_n=0, the block SHALL force state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, counter=0 and last=3, so requester 0 has first priority after reset.
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-025 The first possible grant after reset deassertion SHALL occur at the first rising edge where req != 0.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1), the requester count constant 4 and the index width constant 2.
REQ-027 One sub-module, grant_decoder_2x4, SHALL decode the 2-bit index plus an enable into the one-hot gnt.
REQ-028 The round-robin search SHALL be combinational logic feeding registered outputs.

Verification
REQ-029 Reset then req=0001 -> at the next edge gnt=0001, gnt_idx=0, gnt_valid=1.
REQ-030 req=1111 held with MAX_HOLD=8 -> the grant rotates 0,1,2,3,0, each owner held exactly 8 cycles.
REQ-031 Owner 1 drops req while req=0101 -> the grant moves to 2 at that edge, with no cycle of gnt_valid=0.
REQ-032 Sole requester 3 held for 20 cycles -> gnt=1000 throughout and the counter stays at 7.
REQ-033 rst_n pulled low mid-grant, between edges -> gnt=0 immediately; after release with req=1100 -> grant 2.
REQ-034 Owner 0 drops with req=0000 -> IDLE next edge; then req=0011 -> grant 1 (last=0).

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   state_e   : arbiter state encoding (IDLE = no owner, BUSY = owner held)
//   NUM_REQ   : number of requesters
//   IDX_W     : width of a requester index
//   rr_pick() : round-robin search helper
package rr_arbiter_4_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  // Return the first asserted request searching upward (modulo NUM_REQ)
  // from last+1. The requester 'last' itself is visited at the final
  // position, so it is the lowest-priority candidate. The loop walks the
  // offsets from far to near so the nearest hit overwrites the others.
  // With no request set the result is 'last'; callers only use the
  // result when at least one request is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = last + IDX_W'(off);
      if (req_v[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_grant_decoder_2x4.sv
// 2-to-4 one-hot decoder with enable, used to build the grant vector.
//   idx_i    : binary index of the owner
//   en_i     : enable; when low the output is all zeros
//   onehot_o : one-hot decode of idx_i gated by en_i
module grant_decoder_2x4
  import rr_arbiter_4_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter_4.sv
// 4-requester round-robin arbiter with a bounded hold time.
// An owner keeps the grant while it requests, but after MAX_HOLD
// consecutive cycles it is forced to yield if anybody else is waiting.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request lines, bit i = requester i
//   gnt       : one-hot grant, zero when nobody owns the resource
//   gnt_idx   : binary owner index, zero when nobody owns the resource
//   gnt_valid : high while a grant is held
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  localparam int unsigned     CNT_W   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [NUM_REQ-1:0] others;
  logic [IDX_W-1:0]   winner;

  // Requests from everybody except the current owner.
  assign others = req & ~(NUM_REQ'(1) << owner_q);

  // last_q always equals owner_q while BUSY, so one search from last_q
  // serves both the IDLE grant and every hand-over in BUSY; the owner
  // naturally ends up as the lowest-priority candidate.
  assign winner = rr_pick(req, last_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic new_grant;
    new_grant = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) new_grant = 1'b1;
      end
      ST_BUSY: begin
        if (!req[owner_q]) begin
          // Owner dropped: hand over directly, or fall idle if nobody waits.
          // This takes precedence over expiry so a switch happens only once.
          if (|others) begin
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            owner_d = '0;
            cnt_d   = '0;
          end
        end else if ((cnt_q == CNT_MAX) && (|others)) begin
          new_grant = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (new_grant) begin
      state_d = ST_BUSY;
      owner_d = winner;
      last_d  = winner;
      cnt_d   = '0;
    end
  end

  // Output logic: driven only from registers, no path from req.
  always_comb begin
    gnt_valid = (state_q == ST_BUSY);
    gnt_idx   = gnt_valid ? owner_q : '0;
  end

  grant_decoder_2x4 u_dec (
    .idx_i    (gnt_idx),
    .en_i     (gnt_valid),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all three outputs against the expected owner (or no owner).
  task automatic chk_grant(input string tag, input bit valid, input int owner);
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    e_gnt = valid ? (4'b0001 << owner) : 4'b0000;
    e_idx = valid ? owner[1:0] : 2'd0;
    chk({tag, ".gnt"},   {4'h0, gnt},       {4'h0, e_gnt});
    chk({tag, ".idx"},   {6'h0, gnt_idx},   {6'h0, e_idx});
    chk({tag, ".valid"}, {7'h0, gnt_valid}, {7'h0, valid});
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);

    // Reset state
    @(negedge clk);
    chk_grant("reset", 1'b0, 0);
    rst_n = 1'b1;

    // No combinational path from req, then first grant to requester 0
    req = 4'b0001;
    #1;
    chk_grant("nocomb", 1'b0, 0);
    tick();
    chk_grant("first_r0", 1'b1, 0);
    $display("step first grant: req=0001 gnt=%b", gnt);

    // All four requesting: 0,1,2,3,0 each held 8 cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 33; k++) begin
      tick();
      chk_grant($sformatf("rot_k%0d", k), 1'b1, (k / 8) % 4);
    end
    $display("step rotation: 33 cycles with req=1111");

    // Owner 1 drops while 0 and 2 wait: hands over to 2 with no bubble
    do_reset();
    req = 4'b0010;
    tick();
    chk_grant("drop_own1", 1'b1, 1);
    req = 4'b0101;
    tick();
    chk_grant("drop_to2", 1'b1, 2);
    $display("step owner drop: gnt=%b", gnt);

    // Sole requester 3 for 20 cycles keeps the grant; the saturated
    // counter then forces an immediate hand-over once 0 requests.
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_grant($sformatf("sole3_k%0d", k), 1'b1, 3);
    end
    req = 4'b1001;
    tick();
    chk_grant("sat_rotate", 1'b1, 0);
    $display("step saturation: gnt=%b", gnt);

    // Asynchronous reset mid-grant, then release with 1100
    do_reset();
    req = 4'b0001;
    tick();
    chk_grant("pre_async", 1'b1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_grant("async_rst", 1'b0, 0);
    @(negedge clk);
    req   = 4'b1100;
    rst_n = 1'b1;
    tick();
    chk_grant("post_rst_r2", 1'b1, 2);
    $display("step async reset: gnt=%b", gnt);

    // Owner 0 drops with nobody waiting -> idle; then 0011 -> grant 1
    do_reset();
    req = 4'b0001;
    tick();
    chk_grant("idle_own0", 1'b1, 0);
    req = 4'b0000;
    tick();
    chk_grant("idle", 1'b0, 0);
    req = 4'b0011;
    tick();
    chk_grant("idle_to1", 1'b1, 1);
    $display("step idle return: gnt=%b", gnt);

    // Owner drop coincides with expiry: exactly one advance (to 1, not 2)
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    chk_grant("sim_own0", 1'b1, 0);
    req = 4'b0110;
    tick();
    chk_grant("sim_single", 1'b1, 1);
    $display("step simultaneous drop+expiry: gnt=%b", gnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
